// File: rtl/seq_detect.sv
`default_nettype none
// ============================================================================
// seq_detect : serial pattern detector with Mealy match flag, loadable pattern
//              and optional saturating match counter (macro SEQ_DETECT_COUNT_EN)
// Rev 1.0
// ============================================================================
module seq_detect #(
   parameter int               PAT_W   = 4,
   parameter int               CNT_W   = 8,
   parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(4'b1101)
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             i,
   input  logic             en,
   input  logic             overlap,
   input  logic             load,
   input  logic [PAT_W-1:0] pat_in,
   output logic             o,
   output logic [CNT_W-1:0] match_cnt
);

   localparam int               FILL_W   = $clog2(PAT_W);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

   logic [PAT_W-1:0]  pat_q,  pat_d;
   logic [PAT_W-2:0]  hist_q, hist_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [PAT_W-1:0]  window;
   logic              match;

   // fill_q is held at 0 during reset, so match cannot assert while n_rst is low
   assign window = {hist_q, i};
   assign match  = en & ~load & (fill_q == FILL_MAX) & (window == pat_q);
   assign o      = match;

   always_comb begin
      pat_d  = pat_q;
      hist_d = hist_q;
      fill_d = fill_q;
      if (load) begin
         pat_d  = pat_in;
         hist_d = '0;
         fill_d = '0;
      end else if (en) begin
         if (match && !overlap) begin
            hist_d = '0;
            fill_d = '0;
         end else begin
            hist_d = window[PAT_W-2:0];
            if (fill_q != FILL_MAX) begin
               fill_d = fill_q + FILL_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         pat_q  <= RST_PAT;
         hist_q <= '0;
         fill_q <= '0;
      end else begin
         pat_q  <= pat_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end

`ifdef SEQ_DETECT_COUNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (match && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign match_cnt = cnt_q;
`else
   assign match_cnt = '0;
`endif

endmodule
`default_nettype wire
